// File: rtl/muldiv_pkg.sv
// Shared op codes and FSM states for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the pipeline controller and the muldiv unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opr1;
  logic [WIDTH-1:0] opr2;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, opr1, opr2,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, opr1, opr2,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, shift-subtract-restore for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_hi_nx,
  output logic [WIDTH-1:0] acc_lo_nx
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_sub;
  logic             restore;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    restore = shifted < {1'b0, opnd};
    // remainder stays below the divisor, so the difference always fits WIDTH bits
    rem_sub = shifted[WIDTH-1:0] - opnd;
    if (div_mode) begin
      acc_hi_nx = restore ? shifted[WIDTH-1:0] : rem_sub;
      acc_lo_nx = {acc_lo[WIDTH-2:0], ~restore};
    end else begin
      acc_hi_nx = sum[WIDTH:1];
      acc_lo_nx = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one result bit per cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     ena,
  input  logic     flush,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  state_e           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             is_div_r, sgn_r, s1_r, s2_r, dz_r;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd_r, opr1_r;
  logic [WIDTH-1:0] acc_hi_nx, acc_lo_nx;

  logic             op_arith, op_mt, op_signed, op_div, a_neg, b_neg, accept;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    op_arith  = (bus.op == MULT) || (bus.op == MULTU) || (bus.op == DIV) || (bus.op == DIVU);
    op_mt     = (bus.op == MTHI) || (bus.op == MTLO);
    op_signed = (bus.op == MULT) || (bus.op == DIV);
    op_div    = (bus.op == DIV)  || (bus.op == DIVU);
    a_neg     = op_signed & bus.opr1[WIDTH-1];
    b_neg     = op_signed & bus.opr2[WIDTH-1];
    a_mag     = a_neg ? -bus.opr1 : bus.opr1;
    b_mag     = b_neg ? -bus.opr2 : bus.opr2;
    accept    = ena & bus.start & (state == IDLE) & ~flush & (op_arith | op_mt);
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && op_arith) state_nx = CALC;
        CALC:    if (cnt == '0) state_nx = FIX;
        FIX:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    prod_fix = (sgn_r & (s1_r ^ s2_r)) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix  = (sgn_r & (s1_r ^ s2_r)) ? -acc_lo : acc_lo;
    rem_fix  = (sgn_r & s1_r) ? -acc_hi : acc_hi;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode  (is_div_r),
    .acc_hi    (acc_hi),
    .acc_lo    (acc_lo),
    .opnd      (opnd_r),
    .acc_hi_nx (acc_hi_nx),
    .acc_lo_nx (acc_lo_nx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
      acc_hi          <= '0;
      acc_lo          <= '0;
      opnd_r          <= '0;
      opr1_r          <= '0;
      is_div_r        <= 1'b0;
      sgn_r           <= 1'b0;
      s1_r            <= 1'b0;
      s2_r            <= 1'b0;
      dz_r            <= 1'b0;
    end else if (ena) begin
      bus.busy <= (state_nx != IDLE);
      bus.done <= 1'b0;
      if (accept) begin
        bus.div_by_zero <= 1'b0;
        if (op_mt) begin
          if (bus.op == MTHI) bus.hi <= bus.opr1;
          else                bus.lo <= bus.opr1;
          bus.done <= 1'b1;
        end else begin
          // multiply: acc_lo holds the multiplier; divide: acc_lo holds the dividend
          acc_hi   <= '0;
          acc_lo   <= op_div ? a_mag : b_mag;
          opnd_r   <= op_div ? b_mag : a_mag;
          opr1_r   <= bus.opr1;
          is_div_r <= op_div;
          sgn_r    <= op_signed;
          s1_r     <= a_neg;
          s2_r     <= b_neg;
          dz_r     <= op_div && (bus.opr2 == '0);
          cnt      <= CW'(WIDTH - 1);
        end
      end else if (!flush) begin
        case (state)
          CALC: begin
            acc_hi <= acc_hi_nx;
            acc_lo <= acc_lo_nx;
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
          FIX: begin
            bus.done        <= 1'b1;
            bus.div_by_zero <= dz_r;
            if (dz_r) begin
              bus.hi <= opr1_r;
              bus.lo <= '1;
            end else if (is_div_r) begin
              bus.hi <= rem_fix;
              bus.lo <= quo_fix;
            end else begin
              {bus.hi, bus.lo} <= prod_fix;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit with architectural HI/LO registers. It replaces the single-cycle combinational multiplier in the EXE stage. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. A start/busy/done handshake lets the pipeline controller stall ID/EXE while an operation is in flight. It computes one result bit per cycle and supports an exception-driven flush.

## Interface
Parameters:
- WIDTH, 32: operand, HI and LO width (≥ 4).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- ena  in  1  global CPU enable. When 0, every register holds, including the FSM, counter, HI/LO and done.
- flush  in  1  aborts any in-flight operation (exception/eret).
- start  in  1  request; accepted when ena & start & ~busy & ~flush.
- op  in  3  muldiv_pkg op code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- opr1  in  WIDTH  rs value (multiplicand/dividend, or MTHI/MTLO data).
- opr2  in  WIDTH  rt value (multiplier/divisor).
- busy  out  1  registered; high while an arithmetic op is in flight.
- done  out  1  registered one-cycle pulse; HI/LO hold the new values in that cycle.
- div_by_zero  out  1  set by a DIV/DIVU with opr2==0; cleared on the next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States:
  - IDLE: waits for an accepted start.
  - CALC: runs WIDTH iterations, with a counter counting WIDTH-1 down to 0.
  - FIX: applies the sign correction and writes HI/LO.
  - Transitions: IDLE→CALC on accepting an arithmetic op; CALC→FIX when the counter reaches 0; FIX→IDLE unconditionally.
- Operand capture at acceptance:
  - Signed ops store |opr1| and |opr2| as WIDTH-bit unsigned magnitudes, plus the sign flags.
  - Unsigned ops store the operands unchanged.
- Multiply:
  - Radix-2 shift-add into a 2·WIDTH accumulator.
  - In FIX, the product is negated if sign1^sign2 (signed ops only).
  - {hi,lo} ← product.
- Divide:
  - Restoring division; each iteration does one shift-subtract on a WIDTH+1 remainder.
  - In FIX, the quotient is negated if sign1^sign2 and the remainder takes the sign of the dividend.
  - lo ← quotient, hi ← remainder.
  - Signed overflow (MIN/−1) needs no special case: it yields lo=MIN, hi=0.
- Divide by zero:
  - The full latency is still taken.
  - FIX forces lo = all-ones and hi = opr1 as captured (original signed value), and sets div_by_zero.
- MTHI/MTLO:
  - On acceptance, hi (or lo) ← opr1 at that edge.
  - busy stays 0; done pulses the next cycle.
- flush:
  - Has priority over start and over FIX.
  - Next state is IDLE, busy=0, no done; HI/LO and div_by_zero keep their pre-op values.
- start while busy is ignored. The controller must hold the request until busy falls.

## Timing
- Reset values: busy=0, done=0, div_by_zero=0, hi=0, lo=0, state IDLE, counter 0.
- Arithmetic op accepted at edge E0 (all edges counted with ena=1):
  - busy is 1 from after E0 until after E_{WIDTH+1}.
  - CALC occupies edges E1..E_WIDTH.
  - FIX writes HI/LO at E_{WIDTH+1}; done=1 in the following cycle.
  - Latency is WIDTH+1 cycles, i.e. 33 for WIDTH=32.
- A back-to-back start may be accepted in the done cycle; busy then rises again at that edge.
- ena=0 for N cycles stretches the latency by exactly N. A done pulse that is already asserted holds for those cycles.
- Reset mid-operation returns everything to reset values immediately, without waiting for a clock edge.

## Structure
- Package muldiv_pkg holds:
  - op enum: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6–7 are ignored (no acceptance).
  - State enum: IDLE, CALC, FIX.
- Sub-module muldiv_step: combinational, one iteration (shift-add or shift-subtract-restore), selected by a mode bit. It is instantiated once.
- Top module: FSM, counter, operand/sign capture, FIX negation, HI/LO registers.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → hi=0xFFFFFFFF, lo=0xFFFFFFFA; done exactly 33 cycles after acceptance; busy high 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV 0xFFFFFFF9 (−7) ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x64 ÷ 0 → lo=0xFFFFFFFF, hi=0x64, div_by_zero=1. A following MTLO 0x5 → lo=5 with no busy, div_by_zero=0, done pulse.
- MULT started, flush on cycle 10 → busy=0 next cycle, no done, hi/lo keep prior values. A start asserted while busy is never accepted.
- ena held 0 for 5 cycles mid-DIVU → done at 38 cycles. Async reset during CALC → all outputs 0 before the next edge.
